// File: rtl/pid_sample_sequencer_pkg.sv
// Shared state encoding, gain selectors and helpers for the PID sample sequencer.
package pid_pkg;

    localparam int unsigned W = 16;

    localparam logic [1:0] GAIN_KP = 2'd0;
    localparam logic [1:0] GAIN_KI = 2'd1;
    localparam logic [1:0] GAIN_KD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        LAUNCH = 2'd2,
        WAIT   = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pid_sample_sequencer_tick_gen.sv
// Free-running sample divider: counts 0..SAMPLE_DIV-1 while running, held at 0 otherwise.
module sample_tick_gen #(
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned CW         = $clog2(SAMPLE_DIV)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_tick
);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(SAMPLE_DIV - 1));
    assign o_tick = i_run && w_last;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pid_sample_sequencer.sv
// Runs the PID at a fixed sample rate: snapshot operands, commit shadow gains,
// toggle the PID sample input, then collect the result with a timeout.
module pid_sample_sequencer
    import pid_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned W          = pid_pkg::W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_enable,
    input  logic [W-1:0] i_sp,
    input  logic [W-1:0] i_pv,
    input  logic         i_gain_we,
    input  logic [1:0]   i_gain_sel,
    input  logic [W-1:0] i_gain_data,
    input  logic         i_clr_status,
    output logic [W-1:0] o_pid_sp,
    output logic [W-1:0] o_pid_pv,
    output logic [W-1:0] o_pid_kp,
    output logic [W-1:0] o_pid_ki,
    output logic [W-1:0] o_pid_kd,
    output logic         o_pid_sample,
    input  logic [W-1:0] i_pid_un,
    input  logic         i_pid_valid,
    input  logic         i_pid_overflow,
    output logic [W-1:0] o_un,
    output logic         o_un_valid,
    output logic         o_busy,
    output logic         o_timeout,
    output logic         o_missed,
    output logic [7:0]   o_ovf_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t        r_state;
    logic [W-1:0]  r_sh_kp, r_sh_ki, r_sh_kd;
    logic [W-1:0]  r_sp, r_pv, r_kp, r_ki, r_kd, r_un;
    logic          r_sample, r_un_valid, r_timeout, r_missed;
    logic [7:0]    r_ovf_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          w_run, w_tick, w_busy;

    assign w_run  = (r_state != IDLE);
    assign w_busy = (r_state == LAUNCH) || (r_state == WAIT);

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_run  (w_run),
        .o_tick (w_tick)
    );

    // Shadow bank only reaches the PID through the LAUNCH copy, so a write in
    // the LAUNCH cycle lands after the copy and applies to the next sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_kp <= '0;
            r_sh_ki <= '0;
            r_sh_kd <= '0;
        end else if (i_gain_we) begin
            case (i_gain_sel)
                GAIN_KP: r_sh_kp <= i_gain_data;
                GAIN_KI: r_sh_ki <= i_gain_data;
                GAIN_KD: r_sh_kd <= i_gain_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_sp       <= '0;
            r_pv       <= '0;
            r_kp       <= '0;
            r_ki       <= '0;
            r_kd       <= '0;
            r_un       <= '0;
            r_sample   <= 1'b0;
            r_un_valid <= 1'b0;
            r_timeout  <= 1'b0;
            r_missed   <= 1'b0;
            r_ovf_cnt  <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_un_valid <= 1'b0;

            // Clear first so that a set event in the same cycle wins.
            if (i_clr_status) begin
                r_timeout <= 1'b0;
                r_missed  <= 1'b0;
            end
            if (w_tick && w_busy) begin
                r_missed <= 1'b1;
            end

            if (!i_enable) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: r_state <= ARM;
                    ARM: begin
                        if (w_tick) begin
                            r_state <= LAUNCH;
                        end
                    end
                    LAUNCH: begin
                        r_sp     <= i_sp;
                        r_pv     <= i_pv;
                        r_kp     <= r_sh_kp;
                        r_ki     <= r_sh_ki;
                        r_kd     <= r_sh_kd;
                        r_sample <= ~r_sample;
                        r_to_cnt <= '0;
                        r_state  <= WAIT;
                    end
                    WAIT: begin
                        if (i_pid_valid) begin
                            if (i_pid_overflow) begin
                                r_ovf_cnt <= sat_inc8(r_ovf_cnt);
                            end else begin
                                r_un <= i_pid_un;
                            end
                            r_un_valid <= 1'b1;
                            r_state    <= ARM;
                        end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                            r_timeout <= 1'b1;
                            r_state   <= ARM;
                        end else begin
                            r_to_cnt <= r_to_cnt + TW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_pid_sp     = r_sp;
    assign o_pid_pv     = r_pv;
    assign o_pid_kp     = r_kp;
    assign o_pid_ki     = r_ki;
    assign o_pid_kd     = r_kd;
    assign o_pid_sample = r_sample;
    assign o_un         = r_un;
    assign o_un_valid   = r_un_valid;
    assign o_busy       = w_busy;
    assign o_timeout    = r_timeout;
    assign o_missed     = r_missed;
    assign o_ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// Directed plus randomized bench for pid_sample_sequencer with a stub PID and a
// transaction-level model of operands, result word, flags and launch cadence.
module tb_pid_sample_sequencer;
    import pid_pkg::*;

    localparam int DIV       = 10;
    localparam int TMO       = 8;
    localparam int TMO2      = 16;
    localparam int DW        = 16;
    localparam int TOG_LIMIT = 3 * DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, en2, gwe, clr, pvld, pvld2, povf;
    logic [1:0]    gsel;
    logic [DW-1:0] sp, pv, gdata, pun;

    logic [DW-1:0] o_sp, o_pv, o_kp, o_ki, o_kd, o_un;
    logic          o_sample, o_valid, o_busy, o_to, o_ms;
    logic [7:0]    o_ovf;
    logic [DW-1:0] d2_sp, d2_pv, d2_kp, d2_ki, d2_kd, d2_un;
    logic          d2_sample, d2_valid, d2_busy, d2_to, d2_ms;
    logic [7:0]    d2_ovf;

    pid_sample_sequencer #(.SAMPLE_DIV(DIV), .TIMEOUT(TMO), .W(DW)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_sp(sp), .i_pv(pv),
        .i_gain_we(gwe), .i_gain_sel(gsel), .i_gain_data(gdata), .i_clr_status(clr),
        .o_pid_sp(o_sp), .o_pid_pv(o_pv), .o_pid_kp(o_kp), .o_pid_ki(o_ki), .o_pid_kd(o_kd),
        .o_pid_sample(o_sample), .i_pid_un(pun), .i_pid_valid(pvld), .i_pid_overflow(povf),
        .o_un(o_un), .o_un_valid(o_valid), .o_busy(o_busy), .o_timeout(o_to),
        .o_missed(o_ms), .o_ovf_cnt(o_ovf)
    );

    // Longer timeout lets a slow PID overrun a whole sample period.
    pid_sample_sequencer #(.SAMPLE_DIV(DIV), .TIMEOUT(TMO2), .W(DW)) u_dut_slow (
        .i_clk(clk), .i_rst(rst), .i_enable(en2), .i_sp(sp), .i_pv(pv),
        .i_gain_we(gwe), .i_gain_sel(gsel), .i_gain_data(gdata), .i_clr_status(clr),
        .o_pid_sp(d2_sp), .o_pid_pv(d2_pv), .o_pid_kp(d2_kp), .o_pid_ki(d2_ki), .o_pid_kd(d2_kd),
        .o_pid_sample(d2_sample), .i_pid_un(pun), .i_pid_valid(pvld2), .i_pid_overflow(povf),
        .o_un(d2_un), .o_un_valid(d2_valid), .o_busy(d2_busy), .o_timeout(d2_to),
        .o_missed(d2_ms), .o_ovf_cnt(d2_ovf)
    );

    logic [DW-1:0] m_sh [3];
    logic [DW-1:0] m_act [3];
    logic [DW-1:0] saved [3];
    logic [DW-1:0] m_sp, m_pv, m_un;
    logic          m_sample, m_to, m_ms;
    int            m_ovf, m_pulses, pulse_cnt, nstep, t_last;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        nstep++;
        if (o_valid === 1'b1) pulse_cnt++;
    endtask

    task automatic check_all(input string tag, input logic exp_valid, input logic exp_busy);
        chk({tag, ".sp"},      32'(o_sp),     32'(m_sp));
        chk({tag, ".pv"},      32'(o_pv),     32'(m_pv));
        chk({tag, ".kp"},      32'(o_kp),     32'(m_act[0]));
        chk({tag, ".ki"},      32'(o_ki),     32'(m_act[1]));
        chk({tag, ".kd"},      32'(o_kd),     32'(m_act[2]));
        chk({tag, ".sample"},  32'(o_sample), 32'(m_sample));
        chk({tag, ".un"},      32'(o_un),     32'(m_un));
        chk({tag, ".valid"},   32'(o_valid),  32'(exp_valid));
        chk({tag, ".busy"},    32'(o_busy),   32'(exp_busy));
        chk({tag, ".timeout"}, 32'(o_to),     32'(m_to));
        chk({tag, ".missed"},  32'(o_ms),     32'(m_ms));
        chk({tag, ".ovf"},     32'(o_ovf),    32'(m_ovf));
    endtask

    task automatic write_gain(input logic [1:0] sel, input logic [DW-1:0] val);
        gsel = sel; gdata = val; gwe = 1'b1;
        step();
        gwe = 1'b0;
        if (sel != 2'd3) m_sh[sel] = val;
    endtask

    // Launches must appear exactly 'gap' cycles after the previous one.
    task automatic wait_toggle(input string tag, input int gap, input bit keep_act);
        while (o_sample === m_sample && (nstep - t_last) < TOG_LIMIT) step();
        chk({tag, ".gap"}, 32'(nstep - t_last), 32'(gap));
        m_sample = ~m_sample;
        t_last   = nstep;
        m_sp     = sp;
        m_pv     = pv;
        if (!keep_act) m_act = m_sh;
        check_all(tag, 1'b0, 1'b1);
    endtask

    task automatic respond(input string tag, input int d, input logic ovf, input logic [DW-1:0] val);
        repeat (d) step();
        pvld = 1'b1; povf = ovf; pun = val;
        step();
        pvld = 1'b0; povf = 1'b0;
        if (!ovf) m_un = val;
        else if (m_ovf < 255) m_ovf++;
        m_pulses++;
        check_all(tag, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        int  d;
        bit  late;
        logic do_clr;

        rst = 1'b1; en = 1'b0; en2 = 1'b0; gwe = 1'b0; clr = 1'b0;
        pvld = 1'b0; pvld2 = 1'b0; povf = 1'b0; gsel = '0;
        sp = '0; pv = '0; gdata = '0; pun = '0;
        for (int i = 0; i < 3; i++) begin m_sh[i] = '0; m_act[i] = '0; end
        m_sp = '0; m_pv = '0; m_un = '0; m_sample = 1'b0; m_to = 1'b0; m_ms = 1'b0;
        m_ovf = 0; m_pulses = 0; pulse_cnt = 0; nstep = 0; t_last = 0; late = 1'b0;

        repeat (3) step();
        rst = 1'b0;
        check_all("reset", 1'b0, 1'b0);
        chk("reset2.un", 32'(d2_un), 32'd0);
        chk("reset2.sample", 32'(d2_sample), 32'd0);
        chk("reset2.busy", 32'(d2_busy), 32'd0);
        chk("reset2.flags", 32'({d2_to, d2_ms, d2_valid}), 32'd0);

        // Nominal sample
        write_gain(GAIN_KP, 16'd40);
        sp = 16'd150; pv = 16'd0;
        en = 1'b1;
        t_last = nstep;
        wait_toggle("nominal", DIV + 2, 1'b0);
        chk("nominal.kp40", 32'(o_kp), 32'd40);
        chk("nominal.sp150", 32'(o_sp), 32'd150);
        respond("nominal", 3, 1'b0, 16'd6000);
        step();
        chk("nominal.pulses", 32'(pulse_cnt), 32'd1);

        // Gain isolation, then an overflowed result
        wait_toggle("iso1", DIV, 1'b0);
        write_gain(GAIN_KP, 16'd80);
        chk("iso1.kp_held", 32'(o_kp), 32'd40);
        respond("ovf", 0, 1'b1, 16'h1234);
        chk("ovf.un_held", 32'(o_un), 32'd6000);
        chk("ovf.cnt", 32'(o_ovf), 32'd1);
        wait_toggle("iso2", DIV, 1'b0);
        chk("iso2.kp80", 32'(o_kp), 32'd80);

        // Timeout after TMO WAIT cycles, then relaunch on the next tick
        repeat (TMO - 1) step();
        chk("tmo.pre_flag", 32'(o_to), 32'd0);
        chk("tmo.pre_busy", 32'(o_busy), 32'd1);
        step();
        m_to = 1'b1;
        check_all("tmo", 1'b0, 1'b0);
        chk("tmo.un_held", 32'(o_un), 32'd6000);
        wait_toggle("relaunch", DIV, 1'b0);
        respond("relaunch", 1, 1'b0, 16'($urandom));

        // Randomized samples
        for (int k = 0; k < 12; k++) begin
            sp = 16'($urandom);
            pv = 16'($urandom);
            if (!late && $urandom_range(0, 1) == 1) write_gain(2'($urandom_range(0, 3)), 16'($urandom));
            late = 1'b0;
            wait_toggle("rnd", DIV, 1'b0);
            d = int'($urandom_range(0, 9));
            if (d < TMO) begin
                do_clr = ($urandom_range(0, 2) == 0);
                clr = do_clr;
                if (do_clr) begin m_to = 1'b0; m_ms = 1'b0; end
                respond("rnd_done", d, 1'($urandom_range(0, 3) == 0), 16'($urandom));
                clr = 1'b0;
            end else begin
                repeat (TMO - 1) step();
                clr = 1'b1;
                step();
                clr = 1'b0;
                m_to = 1'b1;
                check_all("rnd_tmo", 1'b0, 1'b0);
                pvld = 1'b1; pun = 16'($urandom); povf = 1'($urandom_range(0, 1));
                step();
                pvld = 1'b0; povf = 1'b0;
                check_all("rnd_ign", 1'b0, 1'b1);
                late = 1'b1;
            end
        end

        // Gain write in the LAUNCH cycle applies one sample later
        wait_toggle("lw0", DIV, 1'b0);
        respond("lw0", 0, 1'b0, 16'($urandom));
        while (nstep - t_last < DIV - 1) step();
        saved = m_sh;
        gsel = GAIN_KI; gdata = 16'hBEEF; gwe = 1'b1;
        step();
        gwe = 1'b0;
        m_sh[1] = 16'hBEEF;
        m_act = saved;
        wait_toggle("lw1", DIV, 1'b1);
        respond("lw1", 0, 1'b0, 16'($urandom));
        wait_toggle("lw2", DIV, 1'b0);
        chk("lw2.ki", 32'(o_ki), 32'hBEEF);
        respond("lw2", 2, 1'b0, 16'($urandom));

        // Overflow counter saturation
        for (int k = 0; k < 256; k++) begin
            wait_toggle("sat", DIV, 1'b0);
            respond("sat", 0, 1'b1, 16'($urandom));
        end
        chk("sat.cnt", 32'(o_ovf), 32'd255);

        en = 1'b0;
        step();
        check_all("dis", 1'b0, 1'b0);
        chk("pulses", 32'(pulse_cnt), 32'(m_pulses));

        // Slow PID overruns the period: dropped tick, then abort mid-WAIT
        en2 = 1'b1;
        t_last = nstep;
        while (d2_sample === 1'b0 && (nstep - t_last) < TOG_LIMIT) step();
        chk("slow.gap", 32'(nstep - t_last), 32'(DIV + 2));
        chk("slow.sp", 32'(d2_sp), 32'(sp));
        repeat (DIV - 2) step();
        chk("slow.missed_pre", 32'(d2_ms), 32'd0);
        step();
        chk("slow.missed", 32'(d2_ms), 32'd1);
        chk("slow.busy", 32'(d2_busy), 32'd1);
        repeat (3) step();
        pvld2 = 1'b1; pun = 16'h0ABC;
        step();
        pvld2 = 1'b0;
        chk("slow.un", 32'(d2_un), 32'h0ABC);
        chk("slow.valid", 32'(d2_valid), 32'd1);
        chk("slow.timeout", 32'(d2_to), 32'd0);
        repeat (7) step();
        chk("slow.relaunch", 32'(d2_sample), 32'd0);
        chk("slow.relaunch_busy", 32'(d2_busy), 32'd1);
        step();
        en2 = 1'b0; pvld2 = 1'b1; pun = 16'hDEAD;
        step();
        pvld2 = 1'b0;
        chk("abort.busy", 32'(d2_busy), 32'd0);
        chk("abort.valid", 32'(d2_valid), 32'd0);
        chk("abort.un", 32'(d2_un), 32'h0ABC);
        pvld2 = 1'b1;
        step();
        pvld2 = 1'b0;
        step();
        chk("idle.valid", 32'(d2_valid), 32'd0);
        chk("idle.un", 32'(d2_un), 32'h0ABC);
        chk("idle.missed_kept", 32'(d2_ms), 32'd1);

        clr = 1'b1;
        step();
        clr = 1'b0;
        m_to = 1'b0; m_ms = 1'b0;
        check_all("clr", 1'b0, 1'b0);
        chk("clr.slow_missed", 32'(d2_ms), 32'd0);
        chk("clr.slow_timeout", 32'(d2_to), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
